note_pitch_mapper: RTL and testbench

- Parametrised, multi-channel successor to the ROM-based note-to-constant mapper.
- Converts a note number plus a fractional pitch-bend into an oscillator phase-increment constant, tagged with a voice/channel id.
- Uses sequential divide-by-12, a 12-entry semitone table, linear bend interpolation and an octave shift with saturation.
- Sits between the voice allocator and the oscillator phase accumulators; the valid/ready handshake lets voices be time-multiplexed through one instance.

---
 rtl/note_pitch_mapper_if.sv | 28 ++
 rtl/note_pitch_mapper.sv | 215 +++++++++++++++++++++
 tb/tb_note_pitch_mapper.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/note_pitch_mapper_if.sv
// Request/result bundle for the note-to-phase-increment mapper.
// The master drives requests and consumes results; the slave is the mapper.
interface note_pitch_mapper_if #(
    parameter int NOTE_W = 9,
    parameter int OUT_W  = 24,
    parameter int FRAC_W = 8,
    parameter int CH_W   = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [NOTE_W-1:0] in_note;
    logic [FRAC_W-1:0] in_frac;
    logic [CH_W-1:0]   in_chan;
    logic              out_valid;
    logic [OUT_W-1:0]  out_const;
    logic [CH_W-1:0]   out_chan;
    logic              out_sat;

    modport master (
        output in_valid, in_note, in_frac, in_chan,
        input  in_ready, out_valid, out_const, out_chan, out_sat
    );

    modport slave (
        input  in_valid, in_note, in_frac, in_chan,
        output in_ready, out_valid, out_const, out_chan, out_sat
    );
endinterface

// File: rtl/note_pitch_mapper.sv
// Note number + fractional bend -> oscillator phase-increment constant.
// Octave/semitone split by repeated subtraction of 12, a 12-entry semitone
// table, linear interpolation toward the next semitone, then an octave
// shift relative to REF_OCT with saturation on overflow.
module note_pitch_mapper #(
    parameter int NOTE_W  = 9,
    parameter int OUT_W   = 24,
    parameter int FRAC_W  = 8,
    parameter int CH_W    = 4,
    parameter int REF_OCT = 10
) (
    input  logic                clk,
    input  logic                reset_reg_N,
    note_pitch_mapper_if.slave  bus
);

    // Largest octave a note can reach and the widest upward shift it implies;
    // the shift datapath is wide enough that nothing wraps before the
    // saturation compare.
    localparam int MAX_OCT = ((1 << NOTE_W) - 1) / 12;
    localparam int MAX_SH  = (MAX_OCT > REF_OCT) ? (MAX_OCT - REF_OCT) : 0;
    localparam int WIDE_W  = (((13 + MAX_SH) > OUT_W) ? (13 + MAX_SH) : OUT_W) + 1;
    localparam int PROD_W  = 13 + FRAC_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DIV    = 3'd1,
        S_LOOK   = 3'd2,
        S_INTERP = 3'd3,
        S_SHIFT  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NOTE_W-1:0] r_rem;
    logic [NOTE_W-1:0] r_oct;
    logic [FRAC_W-1:0] r_frac;
    logic [CH_W-1:0]   r_chan;
    logic [12:0]       r_base;
    logic [12:0]       r_nxt;
    logic [12:0]       r_f;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_out_const;
    logic [CH_W-1:0]   r_out_chan;
    logic              r_out_sat;

    logic [12:0]       w_diff;
    logic [PROD_W-1:0] w_prod;
    logic [12:0]       w_f;
    logic [NOTE_W-1:0] w_sh_up;
    logic [NOTE_W-1:0] w_sh_dn;
    logic [WIDE_W-1:0] w_wide;
    logic [OUT_W-1:0]  w_const;
    logic              w_sat;

    // Base constant of semitone s within the reference octave.
    function automatic logic [12:0] semi_base(input logic [3:0] s);
        logic [12:0] v;
        case (s)
            4'd0:    v = 13'd2608;
            4'd1:    v = 13'd2763;
            4'd2:    v = 13'd2927;
            4'd3:    v = 13'd3101;
            4'd4:    v = 13'd3286;
            4'd5:    v = 13'd3481;
            4'd6:    v = 13'd3688;
            4'd7:    v = 13'd3908;
            4'd8:    v = 13'd4140;
            4'd9:    v = 13'd4386;
            4'd10:   v = 13'd4647;
            4'd11:   v = 13'd4923;
            default: v = 13'd0;
        endcase
        return v;
    endfunction

    // Constant one semitone above s; the top semitone wraps to twice the bottom.
    function automatic logic [12:0] semi_next(input logic [3:0] s);
        logic [12:0] v;
        if (s == 4'd11) begin
            v = 13'd5216;
        end else begin
            v = semi_base(s + 4'd1);
        end
        return v;
    endfunction

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_const = r_out_const;
    assign bus.out_chan  = r_out_chan;
    assign bus.out_sat   = r_out_sat;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_reg_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one accept, divide loop, then three fixed steps.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = S_DIV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DIV: begin
                if (r_rem >= NOTE_W'(12)) begin
                    w_state_nxt = S_DIV;
                end else begin
                    w_state_nxt = S_LOOK;
                end
            end
            S_LOOK:   w_state_nxt = S_INTERP;
            S_INTERP: w_state_nxt = S_SHIFT;
            S_SHIFT:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Linear bend between the current and next semitone, truncating.
    always_comb begin
        w_diff = r_nxt - r_base;
        w_prod = PROD_W'(w_diff) * PROD_W'(r_frac);
        w_f    = r_base + 13'(w_prod >> FRAC_W);
    end

    // Octave shift relative to REF_OCT; overflow is caught on the wide value
    // before it is narrowed to the output width.
    always_comb begin
        w_sh_up = r_oct - NOTE_W'(REF_OCT);
        w_sh_dn = NOTE_W'(REF_OCT) - r_oct;
        w_wide  = WIDE_W'(r_f) << w_sh_up;
        w_const = '0;
        w_sat   = 1'b0;
        if (r_oct >= NOTE_W'(REF_OCT)) begin
            if ((32'(w_sh_up) >= 32'(OUT_W)) && (r_f != 13'd0)) begin
                w_const = '1;
                w_sat   = 1'b1;
            end else if (w_wide > WIDE_W'({OUT_W{1'b1}})) begin
                w_const = '1;
                w_sat   = 1'b1;
            end else begin
                w_const = OUT_W'(w_wide);
                w_sat   = 1'b0;
            end
        end else begin
            if (32'(w_sh_dn) >= 32'd13) begin
                w_const = '0;
            end else begin
                w_const = OUT_W'(r_f >> w_sh_dn);
            end
            w_sat = 1'b0;
        end
    end

    // Datapath and output registers; results hold between strobes.
    always_ff @(posedge clk) begin
        if (!reset_reg_N) begin
            r_rem       <= '0;
            r_oct       <= '0;
            r_frac      <= '0;
            r_chan      <= '0;
            r_base      <= 13'd0;
            r_nxt       <= 13'd0;
            r_f         <= 13'd0;
            r_out_valid <= 1'b0;
            r_out_const <= '0;
            r_out_chan  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_rem  <= bus.in_note;
                        r_oct  <= '0;
                        r_frac <= bus.in_frac;
                        r_chan <= bus.in_chan;
                    end
                end
                S_DIV: begin
                    if (r_rem >= NOTE_W'(12)) begin
                        r_rem <= r_rem - NOTE_W'(12);
                        r_oct <= r_oct + NOTE_W'(1);
                    end
                end
                S_LOOK: begin
                    r_base <= semi_base(r_rem[3:0]);
                    r_nxt  <= semi_next(r_rem[3:0]);
                end
                S_INTERP: begin
                    r_f <= w_f;
                end
                S_SHIFT: begin
                    r_out_const <= w_const;
                    r_out_sat   <= w_sat;
                    r_out_chan  <= r_chan;
                    r_out_valid <= 1'b1;
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_pitch_mapper.sv
// Self-checking bench for note_pitch_mapper: a behavioural reference computes
// each result straight from the note arithmetic, a monitor records accepted
// requests with their due cycle, and one compare process checks every cycle.
module tb_note_pitch_mapper;

    logic clk;
    logic reset_reg_N;

    note_pitch_mapper_if #(.NOTE_W(9), .OUT_W(24), .FRAC_W(8), .CH_W(4)) bus ();

    note_pitch_mapper #(
        .NOTE_W(9), .OUT_W(24), .FRAC_W(8), .CH_W(4), .REF_OCT(10)
    ) dut (
        .clk         (clk),
        .reset_reg_N (reset_reg_N),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int     due;
        longint c;
        int     ch;
        bit     sat;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    bit   rst_seen = 1'b0;
    bit   started  = 1'b0;
    int   n_pass   = 0;
    int   n_tot    = 0;
    int   tbl [12] = '{2608, 2763, 2927, 3101, 3286, 3481,
                       3688, 3908, 4140, 4386, 4647, 4923};

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: octave = note/12, semitone = note%12, bend, then scale by 2^(oct-10).
    function automatic void model(input int note, input int frac,
                                  output longint c, output bit sat);
        int q, s, base, nxt, f, sh;
        longint v;
        q    = note / 12;
        s    = note % 12;
        base = tbl[s];
        nxt  = (s == 11) ? 2 * tbl[0] : tbl[s + 1];
        f    = base + (((nxt - base) * frac) / 256);
        sat  = 1'b0;
        if (q >= 10) begin
            sh = q - 10;
            if (sh >= 24) begin
                c = 64'hFFFFFF; sat = 1'b1;
            end else begin
                v = longint'(f) * (longint'(1) << sh);
                if (v > 64'hFFFFFF) begin
                    c = 64'hFFFFFF; sat = 1'b1;
                end else begin
                    c = v;
                end
            end
        end else begin
            sh = 10 - q;
            c  = (sh >= 13) ? 0 : (f / (1 << sh));
        end
    endfunction

    // Monitor: record acceptances and resets at each rising edge.
    initial begin
        exp_t   e;
        longint c;
        bit     s;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_reg_N) begin
                exp_q.delete();
                rst_seen = 1'b1;
            end else begin
                rst_seen = 1'b0;
                if (bus.in_valid && bus.in_ready) begin
                    model(int'(bus.in_note), int'(bus.in_frac), c, s);
                    e.due = cyc + int'(bus.in_note) / 12 + 4;
                    e.c   = c;
                    e.ch  = int'(bus.in_chan);
                    e.sat = s;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Compare: every falling edge, handshake, strobe timing and held outputs.
    initial begin
        longint last_c  = 0;
        int     last_ch = 0;
        bit     last_s  = 1'b0;
        bit     exp_v, exp_r;
        exp_t   e;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                started = 1'b1;
                chk("rst_in_ready",  longint'(bus.in_ready), 1);
                chk("rst_out_valid", longint'(bus.out_valid), 0);
                chk("rst_out_const", longint'(bus.out_const), 0);
                chk("rst_out_chan",  longint'(bus.out_chan), 0);
                chk("rst_out_sat",   longint'(bus.out_sat), 0);
                last_c = 0; last_ch = 0; last_s = 1'b0;
            end else if (started) begin
                exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                exp_r = (exp_q.size() == 0) || exp_v;
                chk("in_ready",  longint'(bus.in_ready), longint'(exp_r));
                chk("out_valid", longint'(bus.out_valid), longint'(exp_v));
                if (exp_v) begin
                    e = exp_q.pop_front();
                    chk("out_const", longint'(bus.out_const), e.c);
                    chk("out_chan",  longint'(bus.out_chan), longint'(e.ch));
                    chk("out_sat",   longint'(bus.out_sat), longint'(e.sat));
                    last_c = e.c; last_ch = e.ch; last_s = e.sat;
                end else begin
                    chk("hold_const", longint'(bus.out_const), last_c);
                    chk("hold_chan",  longint'(bus.out_chan), longint'(last_ch));
                    chk("hold_sat",   longint'(bus.out_sat), longint'(last_s));
                end
            end
        end
    end

    // Present one request (caller is at a falling edge); hold until accepted.
    task automatic send(input int note, input int frac, input int ch);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_note  = 9'(note);
        bus.in_frac  = 8'(frac);
        bus.in_chan  = 4'(ch);
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            if (bus.in_ready && reset_reg_N) done = 1'b1;
        end
        if (!done) chk("accept_timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected result has been seen.
    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain_timeout", longint'(exp_q.size()), 0);
    endtask

    // Stimulus.
    initial begin
        longint c;
        bit     s;
        reset_reg_N  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_note  = '0;
        bus.in_frac  = '0;
        bus.in_chan  = '0;

        // Hand-computed values that pin the reference model.
        model(120, 0, c, s);   chk("pin_120",     c, 2608);
        model(125, 0, c, s);   chk("pin_125",     c, 3481);
        model(108, 0, c, s);   chk("pin_108",     c, 1304);
        model(0, 0, c, s);     chk("pin_0",       c, 2);
        model(263, 0, c, s);   chk("pin_263",     c, 10082304);
        chk("pin_263_sat", longint'(s), 0);
        model(131, 128, c, s); chk("pin_131_128", c, 5069);
        model(120, 255, c, s); chk("pin_120_255", c, 2762);
        model(275, 0, c, s);   chk("pin_275",     c, 64'hFFFFFF);
        chk("pin_275_sat", longint'(s), 1);
        model(511, 0, c, s);   chk("pin_511",     c, 64'hFFFFFF);
        chk("pin_511_sat", longint'(s), 1);

        repeat (2) @(negedge clk);
        reset_reg_N = 1'b1;

        // Directed plan values, back-to-back.
        send(120, 0, 3);
        send(125, 0, 5);
        send(108, 0, 1);
        send(0, 0, 2);
        send(263, 0, 7);
        send(131, 128, 9);
        send(120, 255, 11);
        send(275, 0, 12);
        send(511, 0, 15);
        drain();

        // Request while busy must be ignored.
        send(200, 17, 4);
        bus.in_valid = 1'b1; bus.in_note = 9'd60; bus.in_chan = 4'd6;
        @(negedge clk);
        bus.in_valid = 1'b0;
        drain();

        // Reset during the divide loop discards the request.
        send(500, 0, 8);
        repeat (5) @(negedge clk);
        reset_reg_N = 1'b0;
        @(negedge clk);
        reset_reg_N = 1'b1;
        repeat (60) @(negedge clk);

        // Randomized traffic with random idle gaps.
        for (int n = 0; n < 200; n++) begin
            send(int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
